// File: rtl/iaddr_unit_if.sv
// rtl/iaddr_unit_if.sv - control-side bus between the control unit and the PC/RAS block
interface iaddr_unit_if #(
  parameter int AW    = 16,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          stall;
  logic [1:0]    nextSel;
  logic [AW-1:0] aluOut;
  logic          call;
  logic [AW-1:0] iAddr;
  logic [CW-1:0] rasCount;
  logic          rasEmpty;
  logic          rasFull;
  logic          rasUnderflow;

  modport master (
    output stall, nextSel, aluOut, call,
    input  iAddr, rasCount, rasEmpty, rasFull, rasUnderflow
  );

  modport slave (
    input  stall, nextSel, aluOut, call,
    output iAddr, rasCount, rasEmpty, rasFull, rasUnderflow
  );
endinterface

// File: rtl/iaddr_unit.sv
// rtl/iaddr_unit.sv - instruction-address register with incrementer, hold/stall and return-address stack
module iaddr_unit #(
  parameter int                AW         = 16,
  parameter int                DEPTH      = 4,
  parameter logic [AW-1:0]     RESET_ADDR = '0,
  parameter logic [AW-1:0]     STEP       = AW'(1)
) (
  input logic         clk,
  input logic         nreset,
  iaddr_unit_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] SEL_SEQ  = 2'b00;
  localparam logic [1:0] SEL_ALU  = 2'b01;
  localparam logic [1:0] SEL_RET  = 2'b10;

  logic [AW-1:0] iaddr_q, iaddr_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          unf_q, unf_d;
  logic [AW-1:0] mem_q [DEPTH];
  logic [AW-1:0] seq;
  logic          push;

  assign seq = iaddr_q + STEP;

  always_comb begin
    iaddr_d = iaddr_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unf_d   = unf_q;
    push    = 1'b0;
    if (!bus.stall) begin
      case (bus.nextSel)
        SEL_SEQ: iaddr_d = seq;
        SEL_ALU: begin
          iaddr_d = bus.aluOut;
          if (bus.call) begin
            // Circular stack: a push when full silently overwrites the oldest entry.
            push  = 1'b1;
            ptr_d = ptr_q + PW'(1);
            cnt_d = (cnt_q == CW'(DEPTH)) ? cnt_q : cnt_q + CW'(1);
          end
        end
        SEL_RET: begin
          if (cnt_q != '0) begin
            iaddr_d = mem_q[ptr_q];
            ptr_d   = ptr_q - PW'(1);
            cnt_d   = cnt_q - CW'(1);
          end else begin
            iaddr_d = seq;
            unf_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      iaddr_q <= RESET_ADDR;
      ptr_q   <= '0;
      cnt_q   <= '0;
      unf_q   <= 1'b0;
    end else begin
      iaddr_q <= iaddr_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage carries no reset; only entries below cnt_q are ever read.
  always_ff @(posedge clk) begin
    if (push) mem_q[ptr_d] <= seq;
  end

  assign bus.iAddr        = iaddr_q;
  assign bus.rasCount     = cnt_q;
  assign bus.rasEmpty     = (cnt_q == '0);
  assign bus.rasFull      = (cnt_q == CW'(DEPTH));
  assign bus.rasUnderflow = unf_q;
endmodule
